// File: rtl/leakyrelu_pkg.sv
// Shared definitions for the leaky-ReLU LUT bank and its load sequencer.
// ST_CHK exists only when LEAKYRELU_LUT_CHK_EN is defined.
package leakyrelu_pkg;

  localparam int LUT_DEPTH = 32;
  localparam int RD_LAT    = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_LOAD  = 3'd2,
`ifdef LEAKYRELU_LUT_CHK_EN
    ST_CHK   = 3'd3,
`endif
    ST_RUN   = 3'd4
  } lut_state_t;

endpackage

// File: rtl/leakyrelu_lut_ctrl_if.sv
// Configuration stream plus the shared LUT write port.
// master = load sequencer side, slave = stream source / RAM bank side.
interface leakyrelu_lut_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] s_data;
  logic              s_vld;
  logic              s_rdy;
  logic              lut_wea;
  logic [ADDR_W-1:0] lut_addra;
  logic [DATA_W-1:0] lut_dina;

  modport master (
    input  s_data, s_vld,
    output s_rdy, lut_wea, lut_addra, lut_dina
  );

  modport slave (
    output s_data, s_vld,
    input  s_rdy, lut_wea, lut_addra, lut_dina
  );
endinterface

// File: rtl/leakyrelu_inflight_trk.sv
// Tracks lookups still travelling through the RD_LAT-deep LUT read pipe.
// idle_o looks at the register contents after this cycle's shift.
module leakyrelu_inflight_trk #(
  parameter int RD_LAT = 2
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic issue_i,
  output logic idle_o
);

  logic [RD_LAT-1:0] sr_q;
  logic [RD_LAT-1:0] sr_d;

  // Shift in this cycle's issue; the oldest entry retires off the top.
  always_comb begin
    sr_d = RD_LAT'({sr_q, issue_i});
  end

  assign idle_o = (sr_d == '0);

  // Shift register state.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/leakyrelu_lut_ctrl.sv
// Load sequencer for the leaky-ReLU LUT bank: drains lookups, streams a new
// table into the RAMs, then re-opens the pixel path. Optional trailer check
// is enabled by defining LEAKYRELU_LUT_CHK_EN.
module leakyrelu_lut_ctrl #(
  parameter int LUT_DEPTH = leakyrelu_pkg::LUT_DEPTH,
  parameter int ADDR_W    = $clog2(LUT_DEPTH),
  parameter int DATA_W    = 64,
  parameter int RD_LAT    = leakyrelu_pkg::RD_LAT
) (
  input  logic                 sclk,
  input  logic                 s_rst_n,
  input  logic                 cfg_start,
  leakyrelu_lut_ctrl_if.master bus,
  input  logic                 pix_vld_i,
  output logic                 pix_vld_o,
  output logic                 pix_stall,
  output logic                 lut_ready,
  output logic                 load_done
`ifdef LEAKYRELU_LUT_CHK_EN
  ,
  output logic                 lut_err
`endif
);
  import leakyrelu_pkg::*;

  lut_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              stall_q, stall_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              issue_s, idle_s, last_s;
`ifdef LEAKYRELU_LUT_CHK_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              err_q, err_d;
`endif

  assign issue_s   = (state_q == ST_RUN) && pix_vld_i;
  assign last_s    = (addr_q == ADDR_W'(LUT_DEPTH - 1));
  assign pix_vld_o = issue_s;
  assign pix_stall = stall_q;
  assign lut_ready = ready_q;
  assign load_done = done_q;
`ifdef LEAKYRELU_LUT_CHK_EN
  assign lut_err   = err_q;
`endif

  leakyrelu_inflight_trk #(.RD_LAT(RD_LAT)) u_trk (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .issue_i (issue_s),
    .idle_o  (idle_s)
  );

  // Next-state, address counter and write-port decode.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    done_d        = 1'b0;
    bus.s_rdy     = 1'b0;
    bus.lut_wea   = 1'b0;
    bus.lut_addra = addr_q;
    bus.lut_dina  = '0;
`ifdef LEAKYRELU_LUT_CHK_EN
    csum_d        = csum_q;
    err_d         = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
`ifdef LEAKYRELU_LUT_CHK_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cfg_start) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (idle_s) begin
          state_d = ST_LOAD;
          addr_d  = '0;
`ifdef LEAKYRELU_LUT_CHK_EN
          csum_d  = '0;
`endif
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_LOAD: begin
        bus.s_rdy = 1'b1;
        if (bus.s_vld) begin
          bus.lut_wea  = 1'b1;
          bus.lut_dina = bus.s_data;
`ifdef LEAKYRELU_LUT_CHK_EN
          csum_d       = csum_q ^ bus.s_data;
`endif
          if (last_s) begin
            addr_d  = '0;
`ifdef LEAKYRELU_LUT_CHK_EN
            state_d = ST_CHK;
`else
            state_d = ST_RUN;
            done_d  = 1'b1;
`endif
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          addr_d = addr_q;
        end
      end
`ifdef LEAKYRELU_LUT_CHK_EN
      ST_CHK: begin
        bus.s_rdy = 1'b1;
        if (bus.s_vld) begin
          if (bus.s_data == csum_q) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_CHK;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Stall and ready track the state they will sit alongside, so they
    // switch on the same edge as the state register.
    stall_d = (state_d != ST_RUN);
    ready_d = (state_d == ST_RUN);
  end

  // State, address and registered status outputs.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      stall_q <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      stall_q <= stall_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

`ifdef LEAKYRELU_LUT_CHK_EN
  // Running XOR of the table and the sticky checksum error flag.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_leakyrelu_lut_ctrl.sv
// Bench for leakyrelu_lut_ctrl: table-driven gating vectors, a write
// scoreboard and hand-written load/reset sequences (LEAKYRELU_LUT_CHK_EN aware).
module tb_leakyrelu_lut_ctrl;

  logic sclk = 1'b0;
  logic s_rst_n, cfg_start, pix_vld_i;
  logic pix_vld_o, pix_stall, lut_ready, load_done;
`ifdef LEAKYRELU_LUT_CHK_EN
  logic lut_err;
`else
  logic lut_err = 1'b0;
`endif

  leakyrelu_lut_ctrl_if #(.ADDR_W(5), .DATA_W(64)) bus ();

  leakyrelu_lut_ctrl dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .cfg_start (cfg_start),
    .bus       (bus),
    .pix_vld_i (pix_vld_i),
    .pix_vld_o (pix_vld_o),
    .pix_stall (pix_stall),
    .lut_ready (lut_ready),
    .load_done (load_done)
`ifdef LEAKYRELU_LUT_CHK_EN
    ,
    .lut_err   (lut_err)
`endif
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    logic cfg, pix, vld;
    logic e_pix, e_stall, e_rdy, e_ready;
  } vec_t;

  wr_t         exp_q[$];
  vec_t        vt[7];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_wr    = 0;
  logic [63:0] xacc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] word(input int seed, input int i);
    logic [7:0]  b;
    logic [63:0] s;
    b = 8'(i);
    s = 64'(seed);
    return {8{b}} ^ (s << 40);
  endfunction

  // Compare every observed RAM write against the scoreboard.
  task automatic monitor();
    wr_t w;
    if (bus.lut_wea === 1'b1) begin
      n_wr++;
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("wr_addr", 64'(bus.lut_addra), 64'(w.addr));
        chk("wr_data", bus.lut_dina, w.data);
      end
    end
  endtask

  task automatic cyc(input logic cfg, input logic pix, input logic vld, input logic [63:0] d);
    @(negedge sclk);
    cfg_start  = cfg;
    pix_vld_i  = pix;
    bus.s_vld  = vld;
    bus.s_data = d;
    #1;
    monitor();
  endtask

  task automatic apply_vec(input int i);
    cyc(vt[i].cfg, vt[i].pix, vt[i].vld, 64'h0BAD_0000_0000_0000);
    chk($sformatf("vec%0d_pix_vld_o", i), 64'(pix_vld_o), 64'(vt[i].e_pix));
    chk($sformatf("vec%0d_pix_stall", i), 64'(pix_stall), 64'(vt[i].e_stall));
    chk($sformatf("vec%0d_s_rdy", i), 64'(bus.s_rdy), 64'(vt[i].e_rdy));
    chk($sformatf("vec%0d_lut_ready", i), 64'(lut_ready), 64'(vt[i].e_ready));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_rdy"}, 64'(bus.s_rdy), 64'd0);
    chk({tag, "_wea"}, 64'(bus.lut_wea), 64'd0);
    chk({tag, "_addra"}, 64'(bus.lut_addra), 64'd0);
    chk({tag, "_dina"}, bus.lut_dina, 64'd0);
    chk({tag, "_pix_vld_o"}, 64'(pix_vld_o), 64'd0);
    chk({tag, "_pix_stall"}, 64'(pix_stall), 64'd1);
    chk({tag, "_lut_ready"}, 64'(lut_ready), 64'd0);
    chk({tag, "_load_done"}, 64'(load_done), 64'd0);
    chk({tag, "_lut_err"}, 64'(lut_err), 64'd0);
  endtask

  task automatic load_words(input int seed, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        cyc(1'b0, 1'b0, 1'b0, 64'd0);
        chk("gap_no_wea", 64'(bus.lut_wea), 64'd0);
      end
      exp_q.push_back('{addr: 5'(i), data: word(seed, i)});
      cyc(1'b0, 1'b0, 1'b1, word(seed, i));
      chk("load_s_rdy", 64'(bus.s_rdy), 64'd1);
      xacc = xacc ^ word(seed, i);
    end
  endtask

  task automatic finish_ok();
`ifdef LEAKYRELU_LUT_CHK_EN
    cyc(1'b0, 1'b0, 1'b1, xacc);
    chk("trailer_s_rdy", 64'(bus.s_rdy), 64'd1);
    chk("trailer_no_wea", 64'(bus.lut_wea), 64'd0);
`endif
    cyc(1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0000);
    chk("done_pulse", 64'(load_done), 64'd1);
    chk("done_lut_ready", 64'(lut_ready), 64'd1);
    chk("done_s_rdy_low", 64'(bus.s_rdy), 64'd0);
    chk("done_pix_stall", 64'(pix_stall), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 64'd0);
    chk("done_one_cycle", 64'(load_done), 64'd0);
  endtask

  task automatic wait_rdy(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 64'd0);
      seen = (bus.s_rdy === 1'b1);
    end
    chk("wait_s_rdy", 64'(seen), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        cfg   pix   vld   e_pix e_stall e_rdy e_ready
    vt[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // IDLE: pixel held off
    vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}; // RUN + cfg_start: still issued
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // DRAIN
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // DRAIN, cfg ignored
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // LOAD, 3 cycles after cfg
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // LOAD, cfg ignored
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    s_rst_n    = 1'b0;
    cfg_start  = 1'b0;
    pix_vld_i  = 1'b1;
    bus.s_vld  = 1'b1;
    bus.s_data = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(negedge sclk);
    #1;
    chk_reset("rst");
    @(negedge sclk);
    s_rst_n = 1'b1;

    apply_vec(0);

    // First load, back-to-back beats
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    chk("idle_cfg_s_rdy", 64'(bus.s_rdy), 64'd0);
    xacc = 64'd0;
    n_wr = 0;
    load_words(1, 32, 1'b0);
    finish_ok();
    chk("load1_writes", 64'(n_wr), 64'd32);

    // Pixel path in RUN, then drain and reload with bubbles
    cyc(1'b0, 1'b1, 1'b0, 64'd0);
    chk("run_pix_vld_o", 64'(pix_vld_o), 64'd1);
    chk("run_pix_stall", 64'(pix_stall), 64'd0);
    for (int i = 1; i < 7; i++) apply_vec(i);
    chk("drain_addr_zero", 64'(bus.lut_addra), 64'd0);
    xacc = 64'd0;
    n_wr = 0;
    load_words(2, 32, 1'b1);
    finish_ok();
    chk("load2_writes", 64'(n_wr), 64'd32);

`ifdef LEAKYRELU_LUT_CHK_EN
    // Corrupted trailer
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    wait_rdy(8);
    xacc = 64'd0;
    load_words(3, 32, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, xacc ^ 64'd1);
    chk("bad_trailer_no_wea", 64'(bus.lut_wea), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 64'd0);
    chk("bad_lut_err", 64'(lut_err), 64'd1);
    chk("bad_lut_ready", 64'(lut_ready), 64'd0);
    chk("bad_no_done", 64'(load_done), 64'd0);
    chk("bad_idle_s_rdy", 64'(bus.s_rdy), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 64'd0);
    chk("err_cleared", 64'(lut_err), 64'd0);
    chk("err_reload_s_rdy", 64'(bus.s_rdy), 64'd1);
    xacc = 64'd0;
    load_words(4, 32, 1'b0);
    finish_ok();
`endif

    // Reset in the middle of a load
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    wait_rdy(8);
    xacc = 64'd0;
    load_words(5, 11, 1'b0);
    @(negedge sclk);
    s_rst_n    = 1'b0;
    cfg_start  = 1'b0;
    pix_vld_i  = 1'b1;
    bus.s_vld  = 1'b1;
    #1;
    chk_reset("midrst");
    @(negedge sclk);
    s_rst_n   = 1'b1;
    pix_vld_i = 1'b0;
    bus.s_vld = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    xacc = 64'd0;
    n_wr = 0;
    load_words(6, 32, 1'b0);
    finish_ok();
    chk("reload_writes", 64'(n_wr), 64'd32);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
